// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Purpose  : Buffers one NxN operand pair and streams it diagonally skewed,
//            zero-padded, into the west/north edges of an NxN systolic array.
//            Optional macro SKEW_FEEDER_AUTOSTART_EN: stream starts as soon
//            as the last load beat is accepted (start input unused).
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 10,
    parameter int N          = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a,
    input  logic [N*DATA_WIDTH-1:0] in_b,
    input  logic                    start,
    output logic                    busy,
    output logic                    out_valid,
    output logic [N*DATA_WIDTH-1:0] a_out,
    output logic [N*DATA_WIDTH-1:0] b_out,
    output logic                    done
);

    localparam int c_cnt_w = $clog2(3*N-2);
    localparam int c_idx_w = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_k_last = c_cnt_w'(N-1);
    localparam logic [c_cnt_w-1:0] c_t_last = c_cnt_w'(3*N-3);
    localparam logic [c_cnt_w-1:0] c_n      = c_cnt_w'(N);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_READY  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [c_cnt_w-1:0]        k_q, k_d;
    logic [c_cnt_w-1:0]        t_q, t_d;
    logic                      busy_q, busy_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic [N*DATA_WIDTH-1:0]   a_q, a_d;
    logic [N*DATA_WIDTH-1:0]   b_q, b_d;

    logic [DATA_WIDTH-1:0]     bufa_q [N][N];
    logic [DATA_WIDTH-1:0]     bufb_q [N][N];

    logic                      w_load_fire;
    logic [c_cnt_w-1:0]        w_ts;
    logic [N*DATA_WIDTH-1:0]   w_a_beat;
    logic [N*DATA_WIDTH-1:0]   w_b_beat;

    assign w_load_fire = (state_q == S_LOAD) && in_valid;

    // Beat index that will be on the outputs after the coming edge.
    assign w_ts = (state_q == S_STREAM) ? (t_q + c_one) : '0;

    always_comb begin : p_beat
        logic [c_cnt_w-1:0] off;
        w_a_beat = '0;
        w_b_beat = '0;
        off      = '0;
        for (int i = 0; i < N; i++) begin
            off = w_ts - c_cnt_w'(i);
            if ((w_ts >= c_cnt_w'(i)) && (off < c_n)) begin
                w_a_beat[i*DATA_WIDTH +: DATA_WIDTH] = bufa_q[i][off[c_idx_w-1:0]];
                w_b_beat[i*DATA_WIDTH +: DATA_WIDTH] = bufb_q[off[c_idx_w-1:0]][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_load_fire) begin
            for (int i = 0; i < N; i++) begin
                bufa_q[i][k_q[c_idx_w-1:0]] <= in_a[i*DATA_WIDTH +: DATA_WIDTH];
                bufb_q[k_q[c_idx_w-1:0]][i] <= in_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        a_d     = '0;
        b_d     = '0;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (k_q == c_k_last) begin
                        k_d = '0;
`ifdef SKEW_FEEDER_AUTOSTART_EN
                        state_d = S_STREAM;
                        t_d     = '0;
                        busy_d  = 1'b1;
                        valid_d = 1'b1;
                        a_d     = w_a_beat;
                        b_d     = w_b_beat;
`else
                        state_d = S_READY;
`endif
                    end else begin
                        k_d = k_q + c_one;
                    end
                end
            end
            S_READY: begin
                if (start) begin
                    state_d = S_STREAM;
                    t_d     = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    a_d     = w_a_beat;
                    b_d     = w_b_beat;
                end
            end
            S_STREAM: begin
                if (t_q == c_t_last) begin
                    state_d = S_DONE;
                    t_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    t_d     = t_q + c_one;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    a_d     = w_a_beat;
                    b_d     = w_b_beat;
                end
            end
            S_DONE:  state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            k_q     <= '0;
            t_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign done      = done_q;
    assign a_out     = a_q;
    assign b_out     = b_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Purpose  : Randomized self-checking bench for systolic_skew_feeder with a
//            matrix-level stream reference and a systolic PE-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

    localparam int DW = 10;
    localparam int N  = 4;
    localparam int L  = 3*N-2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_a;
    logic [N*DW-1:0] in_b;
    logic            start;
    logic            busy;
    logic            out_valid;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            done;

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .a_out     (a_out),
        .b_out     (b_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    int     mat_a [N][N];
    int     mat_b [N][N];
    longint acc   [N][N];
    int     pa    [N][N];
    int     pb    [N][N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected edge vectors at stream beat t, straight from the skew rule.
    function automatic logic [N*DW-1:0] exp_a(input int t);
        logic [N*DW-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t-i >= 0 && t-i < N) v[i*DW +: DW] = DW'(mat_a[i][t-i]);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int t);
        logic [N*DW-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t-j >= 0 && t-j < N) v[j*DW +: DW] = DW'(mat_b[t-j][j]);
        return v;
    endfunction

    task automatic pe_clear();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc[i][j] = 0; pa[i][j] = 0; pb[i][j] = 0;
            end
    endtask

    // One clock of an output-stationary array: multiply-accumulate, pass a east, b south.
    task automatic pe_step(input logic [N*DW-1:0] av, input logic [N*DW-1:0] bv);
        int na [N][N];
        int nb [N][N];
        int ain, bin;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ain = (j == 0) ? int'(av[i*DW +: DW]) : pa[i][j-1];
                bin = (i == 0) ? int'(bv[j*DW +: DW]) : pb[i-1][j];
                acc[i][j] += longint'(ain) * longint'(bin);
                na[i][j] = ain;
                nb[i][j] = bin;
            end
        pa = na;
        pb = nb;
    endtask

    task automatic do_load(input bit gaps, input bit start_mid);
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            if (start_mid && k == 2) begin
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("start_in_load_valid", out_valid, 1'b0);
                check("start_in_load_ready", in_ready, 1'b1);
            end
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                in_a[i*DW +: DW] = DW'(mat_a[i][k]);
                in_b[i*DW +: DW] = DW'(mat_b[k][i]);
            end
            check($sformatf("ready_beat%0d", k), in_ready, 1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic go();
`ifndef SKEW_FEEDER_AUTOSTART_EN
        check("ready_state_in_ready", in_ready, 1'b0);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("ready_wait_valid", out_valid, 1'b0);
            check("ready_wait_in_ready", in_ready, 1'b0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`endif
    endtask

    task automatic do_stream(input int rst_at, input bit hold_valid);
        pe_clear();
        for (int t = 0; t < L; t++) begin
            if (hold_valid) begin
                in_valid = 1'b1;
                in_a = {$urandom, $urandom};
                in_b = {$urandom, $urandom};
            end
            check($sformatf("valid_t%0d", t), out_valid, 1'b1);
            check($sformatf("busy_t%0d", t), busy, 1'b1);
            check($sformatf("done_t%0d", t), done, 1'b0);
            check($sformatf("in_ready_t%0d", t), in_ready, 1'b0);
            check($sformatf("a_out_t%0d", t), a_out, exp_a(t));
            check($sformatf("b_out_t%0d", t), b_out, exp_b(t));
            pe_step(a_out, b_out);
            if (t == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
                check("rst_mid_valid", out_valid, 1'b0);
                check("rst_mid_busy", busy, 1'b0);
                check("rst_mid_a", a_out, '0);
                check("rst_mid_b", b_out, '0);
                check("rst_mid_ready", in_ready, 1'b1);
                check("rst_mid_done", done, 1'b0);
                repeat (L) begin
                    @(negedge clk);
                    check("rst_mid_no_done", done, 1'b0);
                    check("rst_mid_no_valid", out_valid, 1'b0);
                end
                return;
            end
            @(negedge clk);
        end
        check("done_pulse", done, 1'b1);
        check("done_valid", out_valid, 1'b0);
        check("done_busy", busy, 1'b0);
        check("done_a", a_out, '0);
        check("done_b", b_out, '0);
        check("done_in_ready", in_ready, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("after_done_ready", in_ready, 1'b1);
        check("after_done_done", done, 1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                longint s = 0;
                for (int k = 0; k < N; k++) s += longint'(mat_a[i][k]) * longint'(mat_b[k][j]);
                check($sformatf("C%0d%0d", i, j), acc[i][j], s);
            end
    endtask

    task automatic rand_mats();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mat_a[i][j] = int'($urandom_range(0, 1023));
                mat_b[i][j] = int'($urandom_range(0, 1023));
            end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; start = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_a", a_out, '0);
        check("rst_b", b_out, '0);
        // Simultaneous rst and in_valid must not count a beat.
        in_valid = 1'b1;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                mat_a[i][k] = 10*i + k + 1;
                mat_b[i][k] = 100 + 10*i + k;
            end
        do_load(1'b0, 1'b0);
        go();
        do_stream(-1, 1'b0);
        check("C00_known", acc[0][0], 64'd1200);

        for (int trial = 1; trial < 9; trial++) begin
            rand_mats();
            do_load(trial % 2 == 1, trial == 1 || trial == 5);
            go();
            do_stream(trial == 2 ? 5 : -1, trial == 3 || trial == 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream operand feeder for the N×N systolic PE array. Buffers one N×N operand pair (A, B) through a valid/ready load port, then streams it into the array's west edge (A rows) and north edge (B columns) with the diagonal skew the array requires. Row i / column j is delayed by i / j cycles, and zeros are padded before and after each lane's data. Zeros keep streaming until the last product has reached PE[N-1][N-1].

## Interface
Parameters:
- DATA_WIDTH, 10, operand width; matches the PE operand width
- N, 4, array dimension (N ≥ 2)

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  load beat valid
- in_ready  output  1  load beat accepted when in_valid && in_ready
- in_a  input  N*DATA_WIDTH  lane i [i*DATA_WIDTH +: DATA_WIDTH] = A[i][k], where k is the beat index
- in_b  input  N*DATA_WIDTH  lane j = B[k][j]
- start  input  1  begin streaming; honoured only in READY
- busy  output  1  high in STREAM
- out_valid  output  1  a_out/b_out carry a stream beat
- a_out  output  N*DATA_WIDTH  lane i drives array row i, west input a
- b_out  output  N*DATA_WIDTH  lane j drives array column j, north input b
- done  output  1  one-cycle pulse after the final stream beat

## Operation
- Storage: two N×N DATA_WIDTH register arrays, bufA and bufB.
- States: LOAD, READY, STREAM, DONE. Reset state is LOAD.
- LOAD:
  - in_ready = 1.
  - Each accepted beat writes bufA[i][k] and bufB[k][j] for all lanes, then increments the beat counter k.
  - Beat k = N-1 moves the state to READY and clears k.
- READY:
  - in_ready = 0.
  - start = 1 moves the state to STREAM and clears the stream counter t.
  - start in any other state is ignored and is not remembered.
- STREAM: t runs from 0 to 3N-3, incrementing every cycle. No stalls; the array has no backpressure.
  - a_out lane i = bufA[i][t-i] when 0 ≤ t-i ≤ N-1, otherwise 0.
  - b_out lane j = bufB[t-j][j] when 0 ≤ t-j ≤ N-1, otherwise 0.
  - After t = 3N-3, the state moves to DONE.
- DONE: lasts one cycle, then returns to LOAD. Buffer contents are retained but get overwritten by the next load.
- in_valid outside LOAD is ignored; no beat is consumed.
- Arithmetic: none on data. Operands pass through unmodified.
- t and k are $clog2(3N-2) bits wide.

## Timing
- Reset values, valid once rst has been sampled: in_ready = 1, busy = 0, out_valid = 0, done = 0, a_out = 0, b_out = 0, k = 0, t = 0.
- rst asserted in any state, including mid-LOAD or mid-STREAM, returns the block to LOAD on that edge. A partial load is discarded and no done pulse is generated.
- a_out, b_out, out_valid, busy and done are registered.
- Stream latency:
  - start is sampled high in READY at edge E.
  - Beat t = 0 is visible in the cycle that follows E.
  - out_valid and busy stay high for exactly 3N-2 consecutive cycles.
  - done is high in the cycle immediately after the last beat; a_out and b_out are 0 in that cycle.
- The last nonzero operand (lane N-1, t = 2N-2) is followed by N-1 zero beats. These flush the operands through the array so that PE[N-1][N-1] receives its final product.
- Back-to-back operation:
  - in_ready returns to 1 in the cycle after done.
  - The minimum period between two starts is N + 3N-2 + 2 cycles, with in_valid held high.
- Simultaneous in_valid and rst: rst wins and the beat is not stored.

## Configuration
- SKEW_FEEDER_AUTOSTART_EN
  - Defined: the start input is ignored. Acceptance of load beat N-1 moves the state directly to STREAM; the first beat is visible in the cycle after the final load beat's edge. READY is unreachable.
  - Undefined: READY waits for start as described above.

## Test plan
All scenarios use N = 4 and DATA_WIDTH = 10, with A[i][k] = 10i+k+1 and B[k][j] = 100+10k+j.
- Load 4 beats, then start:
  - a_out lane 0 reads 1, 2, 3, 4, then 0s.
  - a_out lane 2 reads 0, 0, 21, 22, 23, 24, then 0s.
  - b_out lane 3 at t = 3 reads 103.
  - out_valid is high for 10 cycles, then done pulses once.
- start pulsed during LOAD after 2 beats: no stream occurs. After 2 more beats the block sits in READY with in_ready = 0 until start.
- rst asserted at stream t = 5: in the next cycle out_valid = 0, a_out = b_out = 0, done is never asserted, and in_ready = 1.
- in_valid held high through STREAM and DONE: no beats are absorbed. A new load begins the cycle after done, and the next stream reflects the new data.
- Loaded into a behavioural 4×4 PE array model (accumulators cleared by reset before start): after done, the array's accumulated result equals A·B, e.g. C[0][0] = 1·100 + 2·110 + 3·120 + 4·130 = 1200.
- With SKEW_FEEDER_AUTOSTART_EN defined: start is tied low, and the stream begins immediately after the 4th beat with the same lane sequences as scenario 1.
